trap_sequencer: RTL
===================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The module SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 trap_illegal  in  1  single-cycle pulse from control unit: undefined opcode.
REQ-004 trap_overflow  in  1  single-cycle pulse from control unit: ALU overflow.
REQ-005 pc_in  in  64  PC of the faulting instruction, sampled with the trap pulse.
REQ-006 mem_req  out  1  vector-table read request, held until mem_ack.
REQ-007 mem_addr  out  64  vector-table address.
REQ-008 mem_ack  in  1  memory read complete, mem_rdata valid this cycle.
REQ-009 mem_rdata  in  64  handler address read from the vector table.
REQ-010 epc_out  out  64  registered EPC.
REQ-011 cause_out  out  2  registered cause: 0 = illegal, 1 = overflow, 2 = misaligned.
REQ-012 pc_load  out  1  one-cycle strobe: the PC SHALL load pc_next.
REQ-013 pc_next  out  64  handler address.
REQ-014 stall_cpu  out  1  freezes control-unit state advance while high.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, SAVE, REQ_VEC, LOAD_PC, DONE.
REQ-017 IDLE→SAVE on any trap input; otherwise stay in IDLE.
- SAVE: epc_out←pc_in (value captured at trigger), cause_out←cause, one cycle → REQ_VEC.
REQ-018 REQ_VEC: mem_req=1, mem_addr=vector, held constant until mem_ack=1.
- On mem_ack: latch mem_rdata into pc_next → LOAD_PC.
REQ-019 Vector addresses SHALL be: illegal 64'd254, overflow 64'd255, misaligned 64'd253.
REQ-020 LOAD_PC: pc_load=1 for exactly one cycle → DONE; DONE → IDLE after one cycle.
REQ-021 stall_cpu SHALL be high from the cycle after the trigger through DONE inclusive.
- Minimum latency trigger→pc_load: 3 cycles (mem_ack in first REQ_VEC cycle).
REQ-022 Simultaneous triggers: priority misaligned > illegal > overflow; the lower-priority trap is dropped.
REQ-023 Trap inputs arriving while busy=1 SHALL be ignored (no nesting, no queueing).
REQ-024 A 4-bit watchdog SHALL count REQ_VEC cycles.
- If 15 cycles elapse without mem_ack: drop mem_req, pc_next←64'd0, go to LOAD_PC.
REQ-025 mem_ack outside REQ_VEC SHALL be ignored.

Reset
REQ-026 On reset, the next state SHALL be IDLE and every output SHALL be 0, including epc_out, cause_out, pc_next and the watchdog.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence without a pc_load strobe.
- Reset SHALL take priority over simultaneous triggers and mem_ack.

Configuration
REQ-028 Macro TRAP_MISALIGN_EN defined: the module SHALL add a trigger when pc_in[1:0]!=2'b00 is sampled while trap_illegal or trap_overflow is high, with cause 2 and vector 253.
REQ-029 Macro TRAP_MISALIGN_EN undefined: cause_out SHALL never equal 2 and no misaligned logic SHALL exist.

Structure
REQ-030 Package trap_pkg SHALL hold the following shared definitions:
- state enum;
- cause enum;
- the constants VEC_ILLEGAL, VEC_OVERFLOW, VEC_MISALIGN and WDOG_LIMIT=4'd15.
REQ-031 The watchdog SHALL be the sub-module trap_watchdog with ports clk, reset, run, expired.

Verification
REQ-032 Illegal pulse, pc_in=64'h40, mem_ack on first REQ_VEC cycle, mem_rdata=64'h100 -> epc_out=64'h40, cause_out=0, mem_addr=254, pc_load with pc_next=64'h100 three cycles after the trigger.
REQ-033 trap_illegal and trap_overflow asserted in the same cycle -> cause_out=0, mem_addr=254, exactly one pc_load.
REQ-034 mem_ack withheld -> mem_req drops after 15 cycles, pc_load with pc_next=0.
REQ-035 Overflow trigger, then a second trigger during REQ_VEC -> second trigger ignored, epc_out unchanged, single pc_load.
REQ-036 Reset asserted in REQ_VEC -> next cycle: IDLE, all outputs 0, no pc_load.
REQ-037 TRAP_MISALIGN_EN defined, pc_in=64'h42 with trap_overflow -> cause_out=2, mem_addr=253.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the trap sequencer: FSM state, trap cause,
// vector-table addresses and the watchdog limit.
// Optional feature macro: TRAP_MISALIGN_EN (adds the misaligned-PC trap).
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_REQ_VEC = 3'd2,
        ST_LOAD_PC = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL  = 2'd0,
        CAUSE_OVERFLOW = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } cause_t;

    localparam logic [63:0] VEC_ILLEGAL  = 64'd254;
    localparam logic [63:0] VEC_OVERFLOW = 64'd255;
    localparam logic [63:0] VEC_MISALIGN = 64'd253;
    localparam logic [3:0]  WDOG_LIMIT   = 4'd15;

    // Vector-table slot holding the handler address for a given cause.
    function automatic logic [63:0] cause_vec(input cause_t c);
        logic [63:0] v;
        case (c)
            CAUSE_OVERFLOW: v = VEC_OVERFLOW;
`ifdef TRAP_MISALIGN_EN
            CAUSE_MISALIGN: v = VEC_MISALIGN;
`endif
            default:        v = VEC_ILLEGAL;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/trap_watchdog.sv
// Watchdog for the vector-table read: counts consecutive cycles with run
// high and flags the cycle in which the WDOG_LIMIT-th such cycle occurs.
module trap_watchdog
    import trap_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Count while running, clear as soon as run drops.
    always_comb begin
        cnt_d   = run ? (cnt_q + 4'd1) : 4'd0;
        expired = run && (cnt_q == (WDOG_LIMIT - 4'd1));
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: on a trap pulse, saves EPC/cause, fetches the handler
// address from the vector table, strobes pc_load and stalls the CPU for the
// whole sequence. Traps arriving while busy are dropped.
// Optional feature macro: TRAP_MISALIGN_EN (misaligned-PC trap, cause 2).
module trap_sequencer
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        trap_illegal,
    input  logic        trap_overflow,
    input  logic [63:0] pc_in,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [63:0] epc_out,
    output logic [1:0]  cause_out,
    output logic        pc_load,
    output logic [63:0] pc_next,
    output logic        stall_cpu,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [63:0] epc_q, epc_d;
    cause_t      cause_q, cause_d;
    logic [63:0] pc_next_q, pc_next_d;

    logic        trig;
    cause_t      trig_cause;
    logic        wdog_run;
    logic        wdog_expired;

    assign wdog_run = (state_q == ST_REQ_VEC);

    trap_watchdog u_wdog (
        .clk     (clk),
        .reset   (reset),
        .run     (wdog_run),
        .expired (wdog_expired)
    );

    // Trigger detection and priority encode (misaligned > illegal > overflow).
    always_comb begin
        trig       = trap_illegal || trap_overflow;
        trig_cause = trap_illegal ? CAUSE_ILLEGAL : CAUSE_OVERFLOW;
`ifdef TRAP_MISALIGN_EN
        if (trig && (pc_in[1:0] != 2'b00)) trig_cause = CAUSE_MISALIGN;
`endif
    end

    // Next-state logic; EPC and cause are captured on the trigger edge so
    // they are already visible while the FSM sits in SAVE.
    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        pc_next_d = pc_next_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_SAVE;
                    epc_d   = pc_in;
                    cause_d = trig_cause;
                end
            end
            ST_SAVE: state_d = ST_REQ_VEC;
            ST_REQ_VEC: begin
                // A real ack wins over a watchdog expiry in the same cycle.
                if (mem_ack) begin
                    pc_next_d = mem_rdata;
                    state_d   = ST_LOAD_PC;
                end else if (wdog_expired) begin
                    pc_next_d = 64'd0;
                    state_d   = ST_LOAD_PC;
                end
            end
            ST_LOAD_PC: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State registers; reset clears everything and overrides triggers/acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            epc_q     <= 64'd0;
            cause_q   <= CAUSE_ILLEGAL;
            pc_next_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            pc_next_q <= pc_next_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        mem_req   = (state_q == ST_REQ_VEC);
        mem_addr  = mem_req ? cause_vec(cause_q) : 64'd0;
        pc_load   = (state_q == ST_LOAD_PC);
        busy      = (state_q != ST_IDLE);
        stall_cpu = busy;
        epc_out   = epc_q;
        cause_out = cause_q;
        pc_next   = pc_next_q;
    end

endmodule
